// File: rtl/uart_autobaud_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud_pkg
// Description : Shared types and constants for the UART auto-baud detector.
//               It holds the FSM state encoding, the error codes, the output
//               widths and a small absolute-difference helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_autobaud_pkg;

  localparam int          BAUD_VAL_W   = 13;
  localparam int          FRAC_W       = 3;
  // Largest integer divisor the baud generator can take. baud_val = I - 1.
  localparam int unsigned BAUD_INT_MAX = 32'd8192;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE     = 2'd0;
  localparam err_code_t ERR_RANGE    = 2'd1;
  localparam err_code_t ERR_MISMATCH = 2'd2;
  localparam err_code_t ERR_TIMEOUT  = 2'd3;

  // Unsigned |a - b| on 32-bit operands. The counters are zero-extended into
  // it, so it works for any counter width up to 32.
  function automatic logic [31:0] abs_diff(input logic [31:0] a,
                                           input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_edge_sync
// Description : Brings the asynchronous serial line into the clk domain with a
//               two-flop synchronizer. A third flop holds the previous
//               synchronized level, and a falling edge is flagged
//               combinationally.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               rx_i     - raw serial line, idle high
//               fall_o   - high for one cycle per synchronized falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_edge_sync
  import uart_autobaud_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic rx_i,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // All three flops reset to 1 so that leaving reset on an idle line cannot
  // produce a spurious falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_o = prev_q & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/uart_autobaud_detect.sv
`default_nettype none
// ============================================================================
// Module      : uart_autobaud_detect
// Description : Measures a 0x55 (8N1) sync character on the serial line and
//               derives the 13-bit baud value and 3-bit fraction for the
//               16x baud tick generator. The falling edges of 0x55 lie two
//               bit times apart, so five falls span exactly 8 bit times.
// Ports       : clk         - system clock
//               reset_n     - asynchronous active-low reset
//               rx          - raw serial line, idle high
//               arm         - pulse; starts a detection when idle
//               abort       - forces IDLE, takes priority over arm
//               baud_val_o  - detected baud value (I - 1)
//               baud_frac_o - detected fraction in eighths
//               valid       - one-cycle pulse when a new result loads
//               locked      - result held valid
//               busy        - high while ARMED or MEASURE
//               err         - one-cycle error pulse
//               err_code    - 0 none, 1 range, 2 mismatch, 3 timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_autobaud_detect
  import uart_autobaud_pkg::*;
#(
  parameter int CNT_WIDTH = 21,
  parameter int TOL_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  arm,
  input  logic                  abort,
  output logic [BAUD_VAL_W-1:0] baud_val_o,
  output logic [FRAC_W-1:0]     baud_frac_o,
  output logic                  valid,
  output logic                  locked,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int                   QW      = CNT_WIDTH - 3;
  localparam int                   SW      = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   tot_q;       // cycles since the start-bit fall
  logic [CNT_WIDTH-1:0]   pair_q;      // cycles since the most recent fall
  logic [CNT_WIDTH-1:0]   p0_q;        // first 2-bit interval, the reference
  logic [1:0]             edge_idx_q;  // falls seen inside MEASURE
  logic [BAUD_VAL_W-1:0]  baud_val_q;
  logic [FRAC_W-1:0]      baud_frac_q;
  logic                   valid_q;
  logic                   locked_q;
  logic                   err_q;
  err_code_t              err_code_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                   w_fall;
  logic [CNT_WIDTH-1:0]   tot_d;
  logic [CNT_WIDTH-1:0]   pair_d;
  logic [QW-1:0]          w_q;         // N / 16, rounded to nearest
  logic [31:0]            w_int;       // integer part of the divisor
  logic                   w_range_bad;
  logic [31:0]            w_dev;
  logic [31:0]            w_tol;
  logic                   w_mismatch;

  uart_rx_edge_sync u_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_i    (rx),
    .fall_o  (w_fall)
  );

  assign tot_d  = tot_q + CNT_ONE;
  assign pair_d = pair_q + CNT_ONE;

  // N is 8 bit times; the 16x tick period in eighths of a clock is
  // 8 * N / 128 = N / 16. Adding 8 before the shift rounds to nearest, and the
  // extra sum bit keeps the addition from wrapping near the top of the range.
  assign w_q         = QW'(({1'b0, tot_q} + SW'(8)) >> 4);
  assign w_int       = 32'(w_q >> 3);
  assign w_range_bad = (w_int == 32'd0) || (w_int > BAUD_INT_MAX);

  // Every later 2-bit interval must stay within P0 >> TOL_SHIFT of P0.
  assign w_dev      = abs_diff(32'(pair_q), 32'(p0_q));
  assign w_tol      = 32'(p0_q >> TOL_SHIFT);
  assign w_mismatch = (w_dev > w_tol);

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tot_q       <= '0;
      pair_q      <= '0;
      p0_q        <= '0;
      edge_idx_q  <= 2'd0;
      baud_val_q  <= '0;
      baud_frac_q <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (abort) begin
        // Abort beats everything, including a fall in the same cycle. It does
        // not raise err and keeps the last err_code for software to read.
        state_q  <= ST_IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm) begin
              state_q    <= ST_ARMED;
              locked_q   <= 1'b0;
              err_code_q <= ERR_NONE;
            end
          end

          ST_ARMED: begin
            if (w_fall) begin
              state_q    <= ST_MEASURE;
              tot_q      <= CNT_ONE;
              pair_q     <= CNT_ONE;
              edge_idx_q <= 2'd0;
            end
          end

          ST_MEASURE: begin
            if (tot_q == CNT_MAX) begin
              // Counter is saturated: hold it and give up.
              err_q      <= 1'b1;
              err_code_q <= ERR_TIMEOUT;
              locked_q   <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              tot_q <= tot_d;
              if (w_fall) begin
                pair_q     <= CNT_ONE;
                edge_idx_q <= edge_idx_q + 2'd1;
                if (edge_idx_q == 2'd0) begin
                  p0_q <= pair_q;
                end else if (w_mismatch) begin
                  // Checked before range, so a bad 4th interval reports
                  // as a mismatch even if N is also out of range.
                  err_q      <= 1'b1;
                  err_code_q <= ERR_MISMATCH;
                  locked_q   <= 1'b0;
                  state_q    <= ST_IDLE;
                end else if (edge_idx_q == 2'd3) begin
                  state_q <= ST_IDLE;
                  if (w_range_bad) begin
                    err_q      <= 1'b1;
                    err_code_q <= ERR_RANGE;
                    locked_q   <= 1'b0;
                  end else begin
                    baud_val_q  <= BAUD_VAL_W'(w_int - 32'd1);
                    baud_frac_q <= w_q[FRAC_W-1:0];
                    locked_q    <= 1'b1;
                    valid_q     <= 1'b1;
                  end
                end
              end else begin
                pair_q <= pair_d;
              end
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign baud_val_o  = baud_val_q;
  assign baud_frac_o = baud_frac_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_autobaud_detect
// Description : Self-checking bench for uart_autobaud_detect. It drives 0x55
//               frames described by their four 2-bit intervals, predicts the
//               outcome arithmetically, and checks every output each cycle.
//               A second instance with narrow counters covers the timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_autobaud_detect;

  localparam int K_OK    = 0;
  localparam int K_RANGE = 1;
  localparam int K_MIS   = 2;
  localparam int K_ABORT = 3;
  // A raw transition driven in cycle d shows up as an FSM action visible in
  // cycle d + 3: two synchronizer stages, then the registered update.
  localparam int LAT     = 3;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        rx      = 1'b1;
  logic        arm     = 1'b0;
  logic        abort   = 1'b0;
  logic [12:0] baud_val_o;
  logic [2:0]  baud_frac_o;
  logic        valid, locked, busy, err;
  logic [1:0]  err_code;

  logic        rx2  = 1'b1;
  logic        arm2 = 1'b0;
  logic [12:0] baud2;
  logic [2:0]  frac2;
  logic        valid2, locked2, busy2, err2;
  logic [1:0]  code2;

  uart_autobaud_detect dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .arm(arm), .abort(abort),
    .baud_val_o(baud_val_o), .baud_frac_o(baud_frac_o), .valid(valid),
    .locked(locked), .busy(busy), .err(err), .err_code(err_code)
  );

  uart_autobaud_detect #(.CNT_WIDTH(12), .TOL_SHIFT(3)) dut_to (
    .clk(clk), .reset_n(reset_n), .rx(rx2), .arm(arm2), .abort(1'b0),
    .baud_val_o(baud2), .baud_frac_o(frac2), .valid(valid2),
    .locked(locked2), .busy(busy2), .err(err2), .err_code(code2)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Expected outputs of the main instance.
  logic [12:0] m_baud   = '0;
  logic [2:0]  m_frac   = '0;
  logic        m_valid  = 1'b0;
  logic        m_locked = 1'b0;
  logic        m_busy   = 1'b0;
  logic        m_err    = 1'b0;
  logic [1:0]  m_code   = 2'd0;

  // Pending outcome of the frame in flight.
  int          ev_at      = -1;
  int          ev_kind    = K_OK;
  logic [12:0] ev_baud    = '0;
  logic [2:0]  ev_frac    = '0;
  int          abort_slot = -1;
  int          arm_slot   = -1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                  nm, cyc, act, exp);
  endtask

  // Advance one cycle; drive and update expectations 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    m_valid = 1'b0;
    m_err   = 1'b0;
    abort   = (cyc == abort_slot);
    arm     = (cyc == arm_slot);
    if (cyc == ev_at) begin
      m_busy   = 1'b0;
      m_locked = 1'b0;
      case (ev_kind)
        K_OK: begin
          m_valid  = 1'b1;
          m_locked = 1'b1;
          m_baud   = ev_baud;
          m_frac   = ev_frac;
        end
        K_RANGE: begin m_err = 1'b1; m_code = 2'd1; end
        K_MIS:   begin m_err = 1'b1; m_code = 2'd2; end
        default: ;
      endcase
      ev_at = -1;
    end
  endtask

  // Per-cycle comparison against the expectation set, away from the edge.
  always @(negedge clk) begin
    check("valid",    valid,       m_valid);
    check("err",      err,         m_err);
    check("locked",   locked,      m_locked);
    check("busy",     busy,        m_busy);
    check("err_code", err_code,    m_code);
    check("baud_val", baud_val_o,  m_baud);
    check("frac",     baud_frac_o, m_frac);
  end

  // Arm, then send a 0x55 character given by its four 2-bit intervals.
  // abort_at in 1..4 asserts abort in the cycle that fall is detected.
  task automatic send_frame(input int q0, input int q1, input int q2,
                            input int q3, input int abort_at,
                            input bit mid_arm);
    int p[4];
    int kend, kind, n, q, ii, dev, d0, dk;
    p[0] = q0; p[1] = q1; p[2] = q2; p[3] = q3;
    kend = 4;
    kind = K_OK;
    for (int i = 1; i < 4; i++) begin
      dev = (p[i] > p[0]) ? p[i] - p[0] : p[0] - p[i];
      if (kind == K_OK && dev > p[0] / 8) begin
        kind = K_MIS;
        kend = i + 1;
      end
    end
    n  = p[0] + p[1] + p[2] + p[3];
    q  = (n + 8) / 16;
    ii = q / 8;
    if (kind == K_OK) begin
      if (ii == 0 || ii > 8192) kind = K_RANGE;
      else begin
        ev_baud = 13'(ii - 1);
        ev_frac = 3'(q % 8);
      end
    end
    if (abort_at >= 1 && abort_at <= kend) begin
      kind = K_ABORT;
      kend = abort_at;
    end

    arm = 1'b1;
    tick();
    m_busy = 1'b1; m_locked = 1'b0; m_code = 2'd0;
    tick();
    tick();

    d0 = cyc;
    dk = d0;
    for (int i = 0; i < kend; i++) dk += p[i];
    ev_kind = kind;
    ev_at   = dk + LAT;
    if (kind == K_ABORT) abort_slot = dk + LAT - 1;
    if (mid_arm) arm_slot = d0 + 10;

    for (int i = 0; i < 4; i++) begin
      rx = 1'b0; repeat (p[i] / 2) tick();
      rx = 1'b1; repeat (p[i] - p[i] / 2) tick();
    end
    rx = 1'b0; repeat (p[3] / 2) tick();
    rx = 1'b1;
    while (cyc < dk + LAT + 2) tick();
    repeat (3) tick();
    abort_slot = -1;
    arm_slot   = -1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog cycle %0d: got timeout, expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, r, d, ab;
    int p[4];
    bit early;

    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // 160-clk bits: N = 1280, Q = 80 -> 9 / 0
    send_frame(320, 320, 320, 320, 0, 1'b0);
    check("t1_baud", baud_val_o, 9);
    check("t1_frac", baud_frac_o, 0);
    check("t1_lock", locked, 1);

    // 164-clk bits: N = 1312, Q = 82 -> 9 / 2
    send_frame(328, 328, 328, 328, 0, 1'b0);
    check("t2_baud", baud_val_o, 9);
    check("t2_frac", baud_frac_o, 2);

    // 8-clk bits: I = 0 -> range error, result kept
    send_frame(16, 16, 16, 16, 0, 1'b0);
    check("t3_code", err_code, 1);
    check("t3_lock", locked, 0);
    check("t3_baud", baud_val_o, 9);
    check("t3_frac", baud_frac_o, 2);

    // Third interval off by 80 > 40 -> mismatch
    send_frame(320, 320, 400, 320, 0, 1'b0);
    check("t4_code", err_code, 2);

    // Mismatch on the 4th fall while N is also out of range -> mismatch wins
    send_frame(16, 16, 16, 20, 0, 1'b0);
    check("t4b_code", err_code, 2);

    // Abort together with the 2nd fall: no err, err_code cleared by the arm
    send_frame(320, 320, 320, 320, 2, 1'b0);
    check("t6_code", err_code, 0);
    check("t6_busy", busy, 0);

    // Abort in IDLE drops locked but keeps the value
    send_frame(320, 320, 320, 320, 0, 1'b0);
    abort_slot = cyc + 1;
    tick();
    tick();
    m_locked = 1'b0;
    abort_slot = -1;
    check("abort_idle_lock", locked, 0);
    check("abort_idle_baud", baud_val_o, 9);

    // Reset in the middle of a measurement
    arm = 1'b1;
    tick();
    m_busy = 1'b1; m_locked = 1'b0; m_code = 2'd0;
    tick();
    rx = 1'b0; repeat (160) tick();
    rx = 1'b1; repeat (100) tick();
    reset_n = 1'b0;
    m_busy = 1'b0; m_locked = 1'b0; m_code = 2'd0; m_baud = '0; m_frac = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_baud", baud_val_o, 0);
    check("rst_frac", baud_frac_o, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    send_frame(320, 320, 320, 320, 0, 1'b0);
    check("post_rst_baud", baud_val_o, 9);
    check("post_rst_lock", locked, 1);

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      t    = $urandom_range(12, 150);
      p[0] = 2 * t + $urandom_range(0, 3);
      for (int i = 1; i < 4; i++) begin
        r = $urandom_range(0, 4);
        if (r == 0)      p[i] = p[0] + p[0] / 8 + 1 + $urandom_range(0, t / 2);
        else if (r == 1) p[i] = p[0] + p[0] / 8;
        else             p[i] = p[0] - $urandom_range(0, p[0] / 8);
      end
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
      send_frame(p[0], p[1], p[2], p[3], ab, ($urandom_range(0, 3) == 0));
    end

    // Timeout on the 12-bit instance: start bit, then the line stays low.
    // tot = 1 in cycle d+3 and reaches 4095 in cycle d+4097, so err is
    // visible in cycle d+4098.
    arm2 = 1'b1;
    tick();
    arm2 = 1'b0;
    check("to_busy", busy2, 1);
    tick();
    rx2 = 1'b0;
    d = cyc;
    early = 1'b0;
    while (cyc < d + 4098) begin
      tick();
      if (cyc < d + 4098 && (err2 || !busy2)) early = 1'b1;
    end
    check("to_early", early, 0);
    check("to_err", err2, 1);
    check("to_code", code2, 3);
    check("to_busy_low", busy2, 0);
    check("to_lock", locked2, 0);
    tick();
    rx2 = 1'b1;
    check("to_err_pulse", err2, 0);
    check("to_code_hold", code2, 3);
    check("to_valid", valid2, 0);
    check("to_baud", {frac2, baud2}, 0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_autobaud_detect.md
Name: uart_autobaud_detect

Overview:
Receive-side counterpart of the baud clock generator. It measures an incoming 0x55 sync character (8N1) on the serial line and derives the 13-bit baud value and 3-bit fraction that make the generator's 16x tick match the remote transmitter. It sits beside the UART receiver in the APB UART subsystem and feeds the baud_val / BAUD_VAL_FRACTION inputs through a software-visible register or a direct mux.

Parameters:
CNT_WIDTH, 21, width of the measurement counters. 21 covers baud_val 8191, fraction 7, with margin.
TOL_SHIFT, 3, allowed deviation of each 2-bit interval from the first interval, set as first interval >> TOL_SHIFT (12.5%).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rx  in  1  raw serial line, asynchronous, idle high
arm  in  1  single-cycle pulse; starts a detection when idle
abort  in  1  returns the block to IDLE; wins over arm
baud_val_o  out  13  detected baud value
baud_frac_o  out  3  detected fraction, in eighths
valid  out  1  one-cycle pulse when a new result is loaded
locked  out  1  result held valid; cleared by arm or abort
busy  out  1  high in ARMED and MEASURE
err  out  1  one-cycle error pulse
err_code  out  2  0 none, 1 range, 2 mismatch, 3 timeout; held until the next arm

Behaviour:
- Reset is asynchronous on reset_n low. Every output and register clears to 0. The synchronizer flops reset to 1, which is line idle.
- rx passes through a 2-flop synchronizer. fall = prev & ~sync, evaluated combinationally in the cycle it is detected.
- FSM states: IDLE, ARMED, MEASURE.
  - IDLE: on arm, go to ARMED, clear locked and err_code. If busy, arm is ignored.
  - ARMED: on the first fall (start bit), go to MEASURE. Load tot_cnt and pair_cnt with 1 and set edge_idx to 0.
  - MEASURE: tot_cnt and pair_cnt increment every cycle. On each fall, capture pair_cnt as P_i, reload pair_cnt with 1, and increment edge_idx.
    - P_0 is stored as the reference interval.
    - For i = 1..3, if |P_i - P_0| > (P_0 >> TOL_SHIFT), raise a mismatch error.
    - On the 4th fall, N = tot_cnt is the number of clk cycles across 8 bit times. Compute and go to IDLE.
- Computation, with all arithmetic unsigned:
  - Q = (N + 8) >> 4, width CNT_WIDTH-3.
  - I = Q >> 3.
  - If I == 0 or I > 8192, raise a range error.
  - Otherwise baud_val_o = I - 1 and baud_frac_o = Q[2:0]; set locked = 1 and pulse valid.
- Latency: valid, baud_val_o and baud_frac_o are registered and appear in the cycle after the 4th fall is detected. They are stable while locked is high.
- Timeout: if tot_cnt reaches all-ones in MEASURE, it saturates and raises a timeout error. No wrap-around is allowed.
- Any error pulses err for 1 cycle, sets err_code, leaves baud outputs unchanged with locked = 0, and returns to IDLE.
- Simultaneous events:
  - abort and fall in the same cycle: abort wins and nothing is captured.
  - A range check and the 4th-edge mismatch check in the same cycle: mismatch has priority.
- abort in any state returns to IDLE. It does not pulse err and leaves err_code unchanged.
- Reset mid-measurement discards all partial counts.

Decomposition:
- Shared package uart_autobaud_pkg holds:
  - the state enum (IDLE, ARMED, MEASURE);
  - err_code constants ERR_NONE, ERR_RANGE, ERR_MISMATCH, ERR_TIMEOUT;
  - BAUD_VAL_W = 13, FRAC_W = 3 and the max integer constant 8192.
- One natural sub-module, uart_rx_edge_sync: 2-flop synchronizer plus prev flop, outputs fall, reset to idle-high.

Test Plan:
1. Arm, then send 0x55 with a 160-clk bit time -> N = 1280, Q = 80; 3 cycles after the last raw falling edge, valid pulses with baud_val_o = 9, frac = 0, locked = 1.
2. Bit time 164 clk -> N = 1312, Q = 82; baud_val_o = 9, frac = 2. Feed these back into the baud generator and check the 16x tick period averages 10.25 clk.
3. Bit time 8 clk -> N = 64, Q = 4, I = 0; err pulses with err_code = 1, locked = 0, baud outputs keep their previous values.
4. 2-bit intervals of 320, 320, 400, 320 clk -> the deviation of 80 exceeds 40; err pulses with code 2 at the 3rd falling edge and the FSM returns to IDLE.
5. Start bit, then rx held low -> tot_cnt saturates at 2^21-1; err pulses with code 3 and busy drops the next cycle.
6. Apply abort and fall in the same cycle mid-MEASURE -> IDLE with no err. Re-arm with 160-clk bits, then pull reset_n low mid-MEASURE -> all outputs 0 immediately; after release, a fresh arm measures correctly.
